// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Round-robin arbiter that shares the push side of one fifo among nReq
//   producers. One producer owns the grant at a time. Its words are forwarded
//   as fifo pushes for a burst of up to maxBurst accepted words. Priority then
//   rotates to the requester after the owner.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   req            per-requester request; bit i means requester i has a word ready
//   reqData        concatenated words; requester i occupies [i*bW +: bW]
//   ack            one-hot; bit i means requester i's word is pushed this cycle
//   fifoPush       push strobe to the fifo
//   fifoPushData   word being pushed (the owner's slice while granted, else 0)
//   fifoFull       full flag from the fifo
//   grantVld       a requester currently owns the grant
//   grantIdx       index of the current owner (0 when grantVld is low)
//   dbgState       FSM state (0 = IDLE, 1 = GRANT)
//   dbgRrPtr       rotation pointer: where the next arbitration search starts
//   dbgBeatCnt     words accepted so far in the current burst
//
// Handshake: req[i] acts as valid and ack[i] as ready. A word transfers
// on a clock edge only when both are high. A requester keeps req and its
// reqData slice stable until it sees ack. It may drop req only after an ack,
// or before it has been granted. fifoPush is the same transfer seen from the
// fifo side. It never rises while fifoFull is high.

module fifo_push_arbiter #(
    parameter int bW       = 8,
    parameter int nReq     = 4,
    parameter int maxBurst = 4,
    parameter int idxW     = $clog2(nReq),
    parameter int bcW      = $clog2(maxBurst + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [nReq-1:0]     req,
    input  logic [nReq*bW-1:0]  reqData,
    output logic [nReq-1:0]     ack,
    output logic                fifoPush,
    output logic [bW-1:0]       fifoPushData,
    input  logic                fifoFull,
    output logic                grantVld,
    output logic [idxW-1:0]     grantIdx,
    output logic                dbgState,
    output logic [idxW-1:0]     dbgRrPtr,
    output logic [bcW-1:0]      dbgBeatCnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state_q,    state_d;
    logic [idxW-1:0] owner_q,    owner_d;
    logic [idxW-1:0] rr_ptr_q,   rr_ptr_d;
    logic [bcW-1:0]  beat_cnt_q, beat_cnt_d;

    logic            win_found;
    logic [idxW-1:0] win_idx;
    logic            granted;
    logic            owner_req;
    logic            accept;
    logic            last_beat;
    logic [idxW-1:0] owner_next;

    // Search for the first set req bit, starting at rr_ptr_q and wrapping
    // modulo nReq. The candidate index is reduced by subtraction, so nReq
    // does not have to be a power of two.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < nReq; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= nReq) cand = cand - nReq;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = idxW'(cand);
            end
        end
    end

    assign granted    = (state_q == GRANT);
    assign owner_req  = req[owner_q];
    assign accept     = granted && owner_req && !fifoFull;
    assign last_beat  = ((beat_cnt_q + bcW'(1)) == bcW'(maxBurst));
    assign owner_next = (owner_q == idxW'(nReq - 1)) ? '0 : owner_q + idxW'(1);

    // Grant-side outputs. Only the owner's ack bit can rise. The data path
    // shows the owner's slice even while stalled on full.
    always_comb begin
        ack          = '0;
        fifoPush     = accept;
        fifoPushData = '0;
        grantVld     = granted;
        grantIdx     = '0;
        if (granted) begin
            ack[owner_q] = accept;
            fifoPushData = reqData[int'(owner_q)*bW +: bW];
            grantIdx     = owner_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                // The arbitration cycle never pushes. This costs one bubble per grant.
                if (win_found) begin
                    state_d    = GRANT;
                    owner_d    = win_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!owner_req || (accept && last_beat)) begin
                    // Release. The owner competes again from the back of the rotation.
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = owner_next;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + bcW'(1);
                end
                // Otherwise the fifo is full: hold the grant and the beat count.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign dbgState   = state_q[0];
    assign dbgRrPtr   = rr_ptr_q;
    assign dbgBeatCnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter (bW=8, nReq=4, maxBurst=4).
// Inputs change 2 time units after a rising edge. Outputs are checked 1 unit
// later, well clear of the next edge.

module tb_fifo_push_arbiter;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  ack;
    logic        fifo_push;
    logic [7:0]  fifo_push_data;
    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic        dbg_state;
    logic [1:0]  dbg_rr_ptr;
    logic [2:0]  dbg_beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int word_n [4];
    int order  [5];

    always #5 clk = ~clk;

    fifo_push_arbiter #(.bW(8), .nReq(4), .maxBurst(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .reqData      (req_data),
        .ack          (ack),
        .fifoPush     (fifo_push),
        .fifoPushData (fifo_push_data),
        .fifoFull     (fifo_full),
        .grantVld     (grant_vld),
        .grantIdx     (grant_idx),
        .dbgState     (dbg_state),
        .dbgRrPtr     (dbg_rr_ptr),
        .dbgBeatCnt   (dbg_beat_cnt)
    );

    // checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_word(input int i, input logic [7:0] w);
        req_data[i*8 +: 8] = w;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_ack, input logic e_push,
                           input logic [7:0] e_data, input logic e_gv, input logic [1:0] e_gi);
        #1;
        chk({tag, ".ack"},  32'(ack),            32'(e_ack));
        chk({tag, ".push"}, 32'(fifo_push),      32'(e_push));
        chk({tag, ".data"}, 32'(fifo_push_data), 32'(e_data));
        chk({tag, ".gvld"}, 32'(grant_vld),      32'(e_gv));
        chk({tag, ".gidx"}, 32'(grant_idx),      32'(e_gi));
    endtask

    task automatic chk_dbg(input string tag, input logic e_st, input logic [1:0] e_rr,
                           input logic [2:0] e_bc);
        chk({tag, ".state"}, 32'(dbg_state),    32'(e_st));
        chk({tag, ".rrptr"}, 32'(dbg_rr_ptr),   32'(e_rr));
        chk({tag, ".beat"},  32'(dbg_beat_cnt), 32'(e_bc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        fifo_full = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
        #2;

        // reset then idle
        for (int c = 0; c < 2; c++) begin
            chk_out("rst", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
            chk_dbg("rst", 1'b0, 2'd0, 3'd0);
            next_cycle();
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk_out("idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
            next_cycle();
        end

        // single requester 2: 4-word burst, bubble, re-grant, drop
        req = 4'b0100;
        set_word(2, 8'hA0);
        chk_out("single.bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            set_word(2, 8'(8'hA0 + k));
            chk_out("single.push", 4'b0100, 1'b1, 8'(8'hA0 + k), 1'b1, 2'd2);
            chk_dbg("single.push", 1'b1, 2'd0, 3'(k));
            next_cycle();
        end
        set_word(2, 8'hA4);
        chk_out("single.bubble2", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        chk_dbg("single.bubble2", 1'b0, 2'd3, 3'd0);
        next_cycle();
        for (int k = 4; k < 6; k++) begin
            set_word(2, 8'(8'hA0 + k));
            chk_out("single.push2", 4'b0100, 1'b1, 8'(8'hA0 + k), 1'b1, 2'd2);
            next_cycle();
        end
        req = 4'b0000;
        chk_out("single.drop", 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd2);
        next_cycle();
        chk_dbg("single.after", 1'b0, 2'd3, 3'd0);

        // round-robin fairness with all four requesting
        do_reset();
        for (int i = 0; i < 4; i++) begin
            word_n[i] = 0;
            set_word(i, 8'(16 * i));
        end
        order = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            chk_out("rr.bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
            chk_dbg("rr.bubble", 1'b0, 2'(order[n]), 3'd0);
            next_cycle();
            for (int b = 0; b < 4; b++) begin
                chk_out("rr.push", 4'(1 << order[n]), 1'b1,
                        8'(16 * order[n] + word_n[order[n]]), 1'b1, 2'(order[n]));
                next_cycle();
                word_n[order[n]]++;
                set_word(order[n], 8'(16 * order[n] + word_n[order[n]]));
            end
        end
        chk_dbg("rr.end", 1'b0, 2'd1, 3'd0);

        // full stall mid-burst, owner 1; requester 0 arrives during the stall
        do_reset();
        req = 4'b0010;
        set_word(1, 8'h50);
        chk_out("full.bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            chk_out("full.push", 4'b0010, 1'b1, 8'(8'h50 + b), 1'b1, 2'd1);
            next_cycle();
            set_word(1, 8'(8'h51 + b));
        end
        fifo_full = 1'b1;
        req = 4'b0011;
        set_word(0, 8'h60);
        for (int c = 0; c < 3; c++) begin
            chk_out("full.stall", 4'b0000, 1'b0, 8'h52, 1'b1, 2'd1);
            chk_dbg("full.stall", 1'b1, 2'd0, 3'd2);
            next_cycle();
        end
        fifo_full = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk_out("full.resume", 4'b0010, 1'b1, 8'(8'h52 + b), 1'b1, 2'd1);
            next_cycle();
            set_word(1, 8'(8'h53 + b));
        end
        chk_out("full.release", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        chk_dbg("full.release", 1'b0, 2'd2, 3'd0);
        next_cycle();
        chk_out("full.next", 4'b0001, 1'b1, 8'h60, 1'b1, 2'd0);
        next_cycle();
        req = 4'b0000;
        next_cycle();
        next_cycle();

        // early drop by owner 3 after one push
        do_reset();
        req = 4'b1000;
        set_word(3, 8'h30);
        chk_out("drop.bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        next_cycle();
        chk_out("drop.push", 4'b1000, 1'b1, 8'h30, 1'b1, 2'd3);
        next_cycle();
        req = 4'b0011;
        set_word(0, 8'h01);
        set_word(1, 8'h11);
        chk_out("drop.release", 4'b0000, 1'b0, 8'h30, 1'b1, 2'd3);
        next_cycle();
        chk_out("drop.idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        chk_dbg("drop.idle", 1'b0, 2'd0, 3'd0);
        next_cycle();
        chk_out("drop.grant0", 4'b0001, 1'b1, 8'h01, 1'b1, 2'd0);
        next_cycle();
        req = 4'b0000;
        next_cycle();
        next_cycle();

        // reset mid-burst (owner 2, two beats in)
        do_reset();
        req = 4'b0100;
        set_word(2, 8'hC0);
        chk_out("rstmid.bubble", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            chk_out("rstmid.push", 4'b0100, 1'b1, 8'(8'hC0 + b), 1'b1, 2'd2);
            next_cycle();
            set_word(2, 8'(8'hC1 + b));
        end
        chk_dbg("rstmid.mid", 1'b1, 2'd0, 3'd2);
        rst = 1'b1;
        req = 4'b1000;
        set_word(3, 8'hD0);
        chk_out("rstmid.rstcyc", 4'b0000, 1'b0, 8'hC2, 1'b1, 2'd2);
        next_cycle();
        rst = 1'b0;
        chk_out("rstmid.idle", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        chk_dbg("rstmid.idle", 1'b0, 2'd0, 3'd0);
        next_cycle();
        chk_out("rstmid.grant3", 4'b1000, 1'b1, 8'hD0, 1'b1, 2'd3);
        next_cycle();

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares the push side of one fifo instance between nReq producers.
- Grants one producer at a time and forwards its data words as fifo pushes.
- Holds each grant for a burst of up to maxBurst accepted words, then rotates priority.
- Sits directly in front of fifo: its fifoPush/fifoPushData/fifoFull ports wire to the fifo's push/pushData/full ports.

Parameters:
- bW, 8, data word width; must equal the fifo's bW.
- nReq, 4, number of requesters; legal range 2 or more.
- maxBurst, 4, maximum words accepted per grant; legal range 1 or more.
- idxW, $clog2(nReq), width of the owner index and rotation pointer.
- bcW, $clog2(maxBurst+1), width of the beat counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  nReq  per-requester request; bit i means requester i has a word on its reqData slice.
- reqData  in  nReq*bW  concatenated data; requester i occupies bits [i*bW +: bW].
- ack  out  nReq  one-hot; bit i high means requester i's word is pushed this cycle.
- fifoPush  out  1  push strobe to fifo.
- fifoPushData  out  bW  data to fifo.
- fifoFull  in  1  fifo full flag.
- grantVld  out  1  a requester currently owns the grant.
- grantIdx  out  idxW  index of the current owner; 0 when grantVld is low.

Behaviour:
- State registers: state {IDLE, GRANT}, owner[idxW], rrPtr[idxW], beatCnt[bcW].
- Reset (rst high at a clock edge): state=IDLE, owner=0, rrPtr=0, beatCnt=0. This applies mid-burst too: any in-progress grant is dropped with no further push.
- Outputs in IDLE: ack=0, fifoPush=0, grantVld=0, grantIdx=0, fifoPushData=0.
- IDLE transition:
  - If any req bit is set, the winner is the first set bit searching from rrPtr upward, modulo nReq.
  - Next cycle: state=GRANT, owner=winner, beatCnt=0.
  - No push occurs in the arbitration cycle; one bubble cycle per grant is intended.
- GRANT outputs (combinational):
  - accept = req[owner] && !fifoFull.
  - fifoPush = accept; ack[owner] = accept; all other ack bits 0.
  - fifoPushData = reqData slice of owner, regardless of accept.
  - grantVld = 1; grantIdx = owner.
- GRANT transition, evaluated each cycle:
  - If req[owner] is low: release.
  - Else if accept and beatCnt+1 == maxBurst: release.
  - Else if accept: beatCnt increments and state stays GRANT.
  - Else (fifoFull high): hold; beatCnt unchanged, state stays GRANT. Full never causes release.
- Release: state=IDLE, beatCnt=0, rrPtr = (owner+1) mod nReq. Wrap from nReq-1 goes to 0.
- Requester rule: a requester must hold req and reqData stable until ack. It may drop req only after an ack, or before it is granted.
- fifo rules: fifoPush is never asserted while fifoFull is high, so the fifo's never-push-when-full assumption holds. At most one push per cycle.
- Simultaneous events:
  - Other requesters' req changes during GRANT are ignored until release.
  - The last beat of a burst and a new req from the owner in the same cycle still release; the owner re-competes through rrPtr.
- Latency: first push occurs 1 cycle after req is seen in IDLE. Back-to-back pushes then occur every cycle while fifo space exists.

Test Plan:
- Reset then idle: rst 2 cycles, req=0 -> ack=0, fifoPush=0, grantVld=0 on every cycle.
- Single requester: req=4'b0100 held, data 8'hA0..A5, maxBurst=4 -> idle bubble, grantIdx=2, pushes A0,A1,A2,A3 on 4 consecutive cycles, 1 idle cycle, re-grant to 2, pushes A4,A5.
- Round-robin fairness: req=4'b1111 continuous -> grants in order 0,1,2,3,0, each with 4 pushes; rrPtr wraps from 3 to 0.
- Full stall: owner 1 mid-burst with beatCnt=2, fifoFull=1 for 3 cycles -> fifoPush=0, ack=0, grantIdx stays 1; after full drops, exactly 2 more pushes, then release.
- Early drop: owner 3 drops req after 1 push -> next cycle IDLE, rrPtr=0; with req=4'b0011 pending, grant goes to 0.
- Reset mid-burst: rst during GRANT with beatCnt=2 -> next cycle state=IDLE, rrPtr=0, no ack; with req=4'b1000 then pending, grantIdx=3 after the bubble.
